// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master across NUM_REQ requesters; optional ACCESS timeout under APB_ARB_TIMEOUT_EN.
// Latency: grant->rsp_valid is 3 cycles + pready wait states; req_ready is offered only in IDLE, so requesters stall while a transfer is in flight.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [ADDR_W-1:0]          paddr,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0]    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant;
  logic [GW-1:0] idx;
  logic          grant_any;
  logic          timeout_hit;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    grant     = last_grant;
    grant_any = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant     = idx;
      end
    end
  end

  assign req_ready = (presetn && state == IDLE && grant_any) ? (NUM_REQ'(1) << grant) : '0;
  assign psel      = (state != IDLE);
  assign penable   = (state == ACCESS);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      paddr      <= '0;
      pwdata     <= '0;
      pwrite     <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            paddr      <= req_addr[grant*ADDR_W +: ADDR_W];
            pwdata     <= req_wdata[grant*DATA_W +: DATA_W];
            pwrite     <= req_write[grant];
            last_grant <= grant;
            state      <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          // A pready arriving on the limit cycle wins over the timeout.
          if (pready) begin
            state     <= IDLE;
            rsp_valid <= NUM_REQ'(1) << last_grant;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (timeout_hit) begin
            state     <= IDLE;
            rsp_valid <= NUM_REQ'(1) << last_grant;
            rsp_rdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  // wait_cnt holds the number of earlier pready=0 ACCESS cycles of this transfer.
  assign timeout_hit = (state == ACCESS) && !pready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= '0;
      rsp_err  <= 1'b0;
    end else begin
      rsp_err <= timeout_hit;
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !pready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign timeout_hit    = 1'b0;
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: requester/APB-slave models drive stimulus, responses are checked against queued expectations.
module tb_apb_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TMO     = 16;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic                      presetn;
  logic [NUM_REQ-1:0]        req_valid, req_ready, req_write, rsp_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]         rsp_rdata, pwdata, prdata;
  logic                      rsp_err, psel, penable, pwrite, pready;
  logic [ADDR_W-1:0]         paddr;

  apb_master_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  typedef struct {
    int          owner;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          gcyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
  } apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  int   grant_log[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [NUM_REQ-1:0] pend, outst, p_write;
  logic [31:0]        p_addr[NUM_REQ];
  logic [31:0]        p_wdata[NUM_REQ];

  int          cfg_waits = 0;
  int          wait_left = 0;
  bit          lat_known = 1'b1;
  bit          exp_timeout = 1'b0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  int          psel_cnt, pen_cnt;
  logic        prev_psel = 1'b0;

  function automatic logic [31:0] data_for(logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  task automatic post(int r, logic w, logic [31:0] a, logic [31:0] d);
    pend[r]    = 1'b1;
    p_write[r] = w;
    p_addr[r]  = a;
    p_wdata[r] = d;
  endtask

  // One clock: APB slave + requester drive after the edge, sampling mid-cycle.
  task automatic tick();
    int                 g;
    rsp_t               e;
    logic [NUM_REQ-1:0] ev;
    if (penable === 1'b1) begin
      if (apb_q.size() > 0) begin
        checks++;
        if (paddr !== apb_q[0].addr || pwrite !== apb_q[0].write || pwdata !== apb_q[0].wdata) begin
          failures++;
          $display("FAIL apb_access: paddr=%h pwrite=%b pwdata=%h, want %h %b %h",
                   paddr, pwrite, pwdata, apb_q[0].addr, apb_q[0].write, apb_q[0].wdata);
        end
      end
      if (wait_left == 0) begin
        pready = 1'b1;
        prdata = ovr_en ? ovr_val : data_for(paddr);
      end else begin
        pready = 1'b0;
        prdata = $urandom;
        wait_left--;
      end
    end else begin
      pready    = 1'($urandom_range(0, 1));
      prdata    = $urandom;
      wait_left = cfg_waits;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]                = pend[i];
      req_write[i]                = p_write[i];
      req_addr[i*ADDR_W +: ADDR_W]  = p_addr[i];
      req_wdata[i*DATA_W +: DATA_W] = p_wdata[i];
    end
    #4;
    psel_cnt += int'(psel);
    pen_cnt  += int'(penable);
    if (psel === 1'b1 && penable === 1'b0) begin
      checks++;
      if (prev_psel !== 1'b0) begin
        failures++;
        $display("FAIL setup_gap: psel was %b in the cycle before SETUP, want 0", prev_psel);
      end
    end
    prev_psel = psel;
    if (req_ready !== '0) begin
      checks++;
      if ($countones(req_ready) != 1 || (req_ready & ~pend) != '0) begin
        failures++;
        $display("FAIL grant: req_ready=%b with pending=%b, want one-hot within pending", req_ready, pend);
      end else begin
        g = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
        apb_q.push_back('{addr: p_addr[g], wdata: p_wdata[g], write: p_write[g]});
        e.owner = g;
        e.err   = exp_timeout;
        e.rdata = (p_write[g] || exp_timeout) ? 32'h0 : (ovr_en ? ovr_val : data_for(p_addr[g]));
        e.lat   = exp_timeout ? TMO + 2 : (lat_known ? 3 + cfg_waits : -1);
        e.gcyc  = cyc;
        rsp_q.push_back(e);
        pend[g]  = 1'b0;
        outst[g] = 1'b1;
        grant_log.push_back(g);
      end
    end
    if (rsp_valid !== '0) begin
      checks++;
      if (rsp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
      end else begin
        e  = rsp_q.pop_front();
        if (apb_q.size() > 0) void'(apb_q.pop_front());
        ev = NUM_REQ'(1) << e.owner;
        outst[e.owner] = 1'b0;
        if (rsp_valid !== ev || rsp_rdata !== e.rdata || rsp_err !== e.err ||
            (e.lat >= 0 && cyc - e.gcyc != e.lat)) begin
          failures++;
          $display("FAIL rsp: valid=%b rdata=%h err=%b lat=%0d, want %b %h %b %0d",
                   rsp_valid, rsp_rdata, rsp_err, cyc - e.gcyc, ev, e.rdata, e.err, e.lat);
        end
      end
    end
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic drain(int budget, string name);
    int n = 0;
    while ((pend != '0 || rsp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (pend != '0 || rsp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_budget: pending=%b outstanding=%0d after %0d cycles, want all done", name, pend, rsp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    presetn   = 1'b0;
    pend      = '0;
    outst     = '0;
    p_write   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin p_addr[i] = '0; p_wdata[i] = '0; end
    req_write = '0; req_addr = '0; req_wdata = '0;
    pready    = 1'b1;
    prdata    = 32'hFFFF_FFFF;
    req_valid = '1;
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_state: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h req_ready=%b rsp_valid=%b rsp_rdata=%h rsp_err=%b, want all 0",
               psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    req_valid = '0;
    presetn   = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    cfg_waits = 0; lat_known = 1'b1; grant_log.delete();
    psel_cnt = 0; pen_cnt = 0;
    post(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    drain(20, "single_write");
    checks++;
    if (psel_cnt != 2 || pen_cnt != 1) begin
      failures++;
      $display("FAIL single_write_phases: psel cycles=%0d penable cycles=%0d, want 2 1", psel_cnt, pen_cnt);
    end
    tick(); tick();
    checks++;
    if (paddr !== 32'h0000_0010 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1 || psel !== 1'b0) begin
      failures++;
      $display("FAIL single_write_hold: paddr=%h pwdata=%h pwrite=%b psel=%b, want 00000010 deadbeef 1 0",
               paddr, pwdata, pwrite, psel);
    end
  endtask

  task automatic test_read_wait();
    cfg_waits = 3; lat_known = 1'b1; ovr_en = 1'b1; ovr_val = 32'h1234_5678;
    post(1, 1'b0, 32'h0000_0004, $urandom);
    drain(30, "read_wait");
    ovr_en = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (rsp_rdata !== 32'h1234_5678) begin
      failures++;
      $display("FAIL read_hold: rsp_rdata=%h, want 12345678", rsp_rdata);
    end
  endtask

  task automatic test_contention();
    int issued = 0;
    int n = 0;
    cfg_waits = 1; lat_known = 1'b1; grant_log.delete();
    while ((issued < 4 || pend != '0 || rsp_q.size() != 0) && n < 80) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i] && !outst[i] && issued < 4) begin
          post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          issued++;
        end
      tick();
      n++;
    end
    checks++;
    if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
      failures++;
      $display("FAIL contention_order: %0d grants, order %p, want 0 1 0 1", grant_log.size(), grant_log);
    end
  endtask

  task automatic test_back_to_back();
    int issued = 0;
    int n = 0;
    lat_known = 1'b0;
    while ((issued < 16 || pend != '0 || rsp_q.size() != 0) && n < 400) begin
      cfg_waits = $urandom_range(0, 3);
      for (int i = 0; i < NUM_REQ; i++)
        if (!pend[i] && !outst[i] && issued < 16 && $urandom_range(0, 3) != 0) begin
          post(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
          issued++;
        end
      tick();
      n++;
    end
    checks++;
    if (issued != 16 || pend != '0 || rsp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back: issued=%0d outstanding=%0d, want 16 0", issued, rsp_q.size());
    end
    lat_known = 1'b1;
  endtask

  task automatic test_late_pready();
    cfg_waits = TMO - 1; lat_known = 1'b1; ovr_en = 1'b1; ovr_val = 32'hA5A5_A5A5;
    post(0, 1'b0, 32'h0000_0044, $urandom);
    drain(40, "late_pready");
    ovr_en = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef APB_ARB_TIMEOUT_EN
    cfg_waits = 1000; lat_known = 1'b1; exp_timeout = 1'b1;
    post(1, 1'b0, 32'h0000_0040, $urandom);
    tick();
    exp_timeout = 1'b0;
    drain(40, "timeout");
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      failures++;
      $display("FAIL timeout_release: psel=%b penable=%b, want 0 0", psel, penable);
    end
`else
    cfg_waits = 1000; lat_known = 1'b0;
    post(1, 1'b0, 32'h0000_0040, $urandom);
    repeat (3) tick();
    psel_cnt = 0;
    repeat (110) tick();
    checks++;
    if (psel_cnt != 110 || rsp_q.size() != 1) begin
      failures++;
      $display("FAIL no_timeout: psel high %0d of 110 cycles, outstanding=%0d, want 110 1", psel_cnt, rsp_q.size());
    end
    wait_left = 0;
    drain(10, "no_timeout");
    lat_known = 1'b1;
`endif
    cfg_waits = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    cfg_waits = 5; lat_known = 1'b0;
    post(0, 1'b0, 32'h0000_0020, $urandom);
    while (penable !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (penable !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_reach: penable=%b after %0d cycles, want 1", penable, n);
    end
    presetn = 1'b0;
    #1;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_drop: psel=%b penable=%b, want 0 0", psel, penable);
    end
    pend = '0; outst = '0;
    rsp_q.delete(); apb_q.delete();
    repeat (3) tick();
    presetn = 1'b1;
    tick(); tick();
    cfg_waits = 0; lat_known = 1'b1; grant_log.delete();
    post(0, 1'b1, 32'h0000_0030, $urandom);
    post(1, 1'b1, 32'h0000_0034, $urandom);
    drain(30, "reset_mid");
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 0) begin
      failures++;
      $display("FAIL reset_priority: grants %p, want 0 then 1", grant_log);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_contention();
    test_back_to_back();
    test_late_pready();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Round-robin arbiter and APB master sequencer that shares one APB bus between NUM_REQ internal requesters (test sequencers, a register-init engine, a CPU model).
- Accepts single-beat read/write requests through a valid/ready handshake.
- Drives the APB SETUP/ACCESS phases to the peripheral subsystem.
- Returns read data and completion status to the granted requester.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 16, max ACCESS-phase wait cycles (used only with APB_ARB_TIMEOUT_EN)

Ports:
pclk  in  1  APB clock; all logic is on the rising edge
presetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data, same slicing
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  DATA_W  read data; valid when any rsp_valid bit is high
rsp_err  out  1  timeout flag; valid with rsp_valid
paddr  out  ADDR_W  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready

Behaviour:
- Reset (presetn=0, asynchronous):
  - FSM goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata and rsp_err all go to 0.
  - Round-robin pointer resets so requester 0 has highest priority.
- Reset in the middle of a transfer: psel and penable drop immediately. No rsp_valid is produced, and the transaction is dropped.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel=0, penable=0.
  - If any req_valid is high, grant g = first set bit searching upward (with wrap) from last_grant+1.
  - req_ready[g]=1 combinationally in this cycle only.
  - On the clock edge: latch req_addr/req_wdata/req_write of g into paddr/pwdata/pwrite, set last_grant=g, go to SETUP.
- Requester rules: req_valid and the payload must be held stable until req_ready. The requester may deassert req_valid only after req_ready. Any requester may have at most one transfer outstanding.
- SETUP: psel=1, penable=0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata are held stable.
  - pready=0: stay in ACCESS.
  - pready=1: register prdata into rsp_rdata (write transfers register 0), go to IDLE.
  - rsp_valid[g] pulses in the next cycle (the IDLE cycle), together with rsp_err=0.
- Timing:
  - Minimum 3 cycles per transfer (IDLE grant, SETUP, ACCESS), plus one cycle per pready wait state.
  - No back-to-back ACCESS to SETUP transition; psel is low for at least one cycle between transfers.
- A new grant may occur in the same IDLE cycle that carries the previous rsp_valid pulse.
- Between transfers, paddr, pwdata and pwrite hold their last values. rsp_rdata holds until the next completion.
- pready is ignored outside ACCESS. prdata is sampled only on the completing ACCESS cycle.
- All requesters asserting every cycle gives strict rotation 0,1,..,NUM_REQ-1,0. There is no starvation.

Optional Feature:
Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYCLES with pready still 0, the transfer ends: the FSM goes to IDLE and psel/penable drop.
  - rsp_valid[g] pulses with rsp_err=1 and rsp_rdata=0.
  - If pready=1 arrives in the same cycle as the limit, the transfer completes normally with rsp_err=0.
- Not defined: no counter; ACCESS waits indefinitely for pready, and rsp_err is tied to 0.

Test Plan:
1. Single write: req 0 writes addr 0x0000_0010 with data 0xDEAD_BEEF, pready always 1 -> req_ready[0] in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid[0] in cycle 3; psel high 2 cycles, penable high 1 cycle.
2. Read with wait states: req 1 reads 0x0000_0004, pready=0 for 3 ACCESS cycles, prdata=0x1234_5678 on the pready cycle -> rsp_valid[1] with rsp_rdata=0x1234_5678, rsp_err=0; paddr stable throughout.
3. Contention: both requesters hold req_valid for 4 transfers -> grant order 0,1,0,1; each rsp_valid goes to the matching requester.
4. Reset mid-ACCESS: assert presetn=0 while penable=1 -> psel and penable are 0 in the same cycle; no rsp_valid; after release, req 0 has priority.
5. Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): pready held 0 -> after 16 wait cycles rsp_valid pulses with rsp_err=1 and rsp_rdata=0; without the macro, psel stays high for 100+ cycles.
6. Late pready on limit cycle: pready=1 exactly on the 16th wait cycle with prdata=0xA5A5_A5A5 -> rsp_err=0, rsp_rdata=0xA5A5_A5A5.
